// File: rtl/lut_frame_config_ctrl.sv
// Frame configuration controller: parses a SYNC/header/data word stream
// into a row-wide frame bus and fires one frame strobe per frame.
module lut_frame_config_ctrl #(
  parameter int          NUM_ROWS       = 16,
  parameter int          NUM_COLUMNS    = 16,
  parameter int          FRAMES_PER_COL = 20,
  parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
  parameter logic [31:0] DESYNC_WORD    = 32'hFAB0_FAB0
) (
  input  logic                                 CLK,
  input  logic                                 resetn,
  input  logic [31:0]                          in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [NUM_ROWS*32-1:0]               frame_data,
  output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0] frame_strobe,
  output logic                                 config_active,
  output logic                                 frame_done,
  output logic                                 cfg_err
);

  localparam int SW = NUM_COLUMNS * FRAMES_PER_COL;
  localparam int CW = $clog2(NUM_ROWS + 1);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    STROBE,
    DISCARD
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   row_cnt;
  logic [7:0]      rem_q;
  logic [7:0]      col_q;
  logic [7:0]      frm_q;

  logic            xfer;
  logic [7:0]      hdr_col;
  logic [7:0]      hdr_frm;
  logic [7:0]      hdr_nrows;
  logic            hdr_ok;
  logic            unused_hdr;

  logic            act_set;
  logic            act_clr;
  logic            err_set;
  logic            err_clr;
  logic            load_frame;
  logic            load_discard;
  logic            wr_row;
  logic            dec_rem;
  logic            fire;

  logic [31:0]     sidx;
  logic [SW-1:0]   onehot;

  assign xfer       = in_valid & in_ready;
  assign hdr_col    = in_data[31:24];
  assign hdr_frm    = in_data[23:16];
  assign hdr_nrows  = in_data[7:0];
  assign unused_hdr = ^in_data[15:8];

  assign hdr_ok = (32'(hdr_col) < NUM_COLUMNS)
               && (32'(hdr_frm) < FRAMES_PER_COL)
               && (hdr_nrows != 8'd0)
               && (32'(hdr_nrows) <= NUM_ROWS);

  assign sidx   = 32'(col_q) * 32'(FRAMES_PER_COL) + 32'(frm_q);
  assign onehot = {{(SW-1){1'b0}}, 1'b1} << sidx;

  always_comb begin
    state_d      = state_q;
    act_set      = 1'b0;
    act_clr      = 1'b0;
    err_set      = 1'b0;
    err_clr      = 1'b0;
    load_frame   = 1'b0;
    load_discard = 1'b0;
    wr_row       = 1'b0;
    dec_rem      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer && in_data == SYNC_WORD) begin
          state_d = HEADER;
          act_set = 1'b1;
          err_clr = 1'b1;
        end
      end
      HEADER: begin
        if (xfer) begin
          if (in_data == DESYNC_WORD) begin
            state_d = IDLE;
            act_clr = 1'b1;
          end else if (hdr_ok) begin
            state_d    = DATA;
            load_frame = 1'b1;
          end else begin
            err_set = 1'b1;
            if (hdr_nrows != 8'd0) begin
              state_d      = DISCARD;
              load_discard = 1'b1;
            end
          end
        end
      end
      DATA: begin
        if (xfer) begin
          wr_row  = 1'b1;
          dec_rem = 1'b1;
          if (rem_q == 8'd1) state_d = STROBE;
        end
      end
      STROBE: state_d = HEADER;
      DISCARD: begin
        if (xfer) begin
          dec_rem = 1'b1;
          if (rem_q == 8'd1) state_d = HEADER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe fires the cycle after the last data word lands.
  assign fire = (state_q == DATA) && (state_d == STROBE);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      in_ready      <= 1'b0;
      config_active <= 1'b0;
      cfg_err       <= 1'b0;
      frame_strobe  <= '0;
      frame_done    <= 1'b0;
      frame_data    <= '0;
      row_cnt       <= '0;
      rem_q         <= '0;
      col_q         <= '0;
      frm_q         <= '0;
    end else begin
      state_q      <= state_d;
      in_ready     <= (state_d != STROBE);
      frame_strobe <= fire ? onehot : '0;
      frame_done   <= fire;
      if (act_set) config_active <= 1'b1;
      else if (act_clr) config_active <= 1'b0;
      if (err_clr) cfg_err <= 1'b0;
      else if (err_set) cfg_err <= 1'b1;
      if (load_frame) begin
        col_q   <= hdr_col;
        frm_q   <= hdr_frm;
        row_cnt <= '0;
        rem_q   <= hdr_nrows;
      end else if (load_discard) begin
        rem_q <= hdr_nrows;
      end else if (dec_rem) begin
        rem_q <= rem_q - 8'd1;
      end
      if (wr_row) row_cnt <= row_cnt + CW'(1);
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (wr_row && row_cnt == CW'(r))
          frame_data[r*32 +: 32] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_lut_frame_config_ctrl.sv
// Randomized bench for lut_frame_config_ctrl with a word-level
// reference parser and per-cycle output comparison.
module tb_lut_frame_config_ctrl;

  localparam int NR  = 16;
  localparam int NC  = 16;
  localparam int FPC = 20;
  localparam int SW  = NC * FPC;
  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

  logic           CLK      = 1'b0;
  logic           resetn   = 1'b1;
  logic [31:0]    in_data  = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [NR*32-1:0] frame_data;
  logic [SW-1:0]  frame_strobe;
  logic           config_active;
  logic           frame_done;
  logic           cfg_err;

  always #5 CLK = ~CLK;

  lut_frame_config_ctrl dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .frame_data    (frame_data),
    .frame_strobe  (frame_strobe),
    .config_active (config_active),
    .frame_done    (frame_done),
    .cfg_err       (cfg_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int gap_max  = 0;

  task automatic chk(input string nm,
                     input logic [NR*32-1:0] got,
                     input logic [NR*32-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h want %h", nm, got, exp);
  endtask

  // Reference parser: 0 unsynced, 1 want header, 2 data, 3 discard
  int          ph;
  bit          m_act;
  bit          m_err;
  bit          m_rdy;
  int          m_left;
  int          m_row;
  int          m_col;
  int          m_frm;
  int          m_sidx;
  logic [31:0] m_rows [NR];

  function automatic void model_reset();
    ph     = 0;
    m_act  = 0;
    m_err  = 0;
    m_rdy  = 0;
    m_left = 0;
    m_row  = 0;
    m_sidx = -1;
    for (int r = 0; r < NR; r++) m_rows[r] = '0;
  endfunction

  function automatic void model_word(input logic [31:0] w);
    int c, f, n;
    c = int'(w[31:24]);
    f = int'(w[23:16]);
    n = int'(w[7:0]);
    case (ph)
      0: if (w == SYNC) begin ph = 1; m_act = 1; m_err = 0; end
      1: begin
        if (w == DESYNC) begin
          ph = 0; m_act = 0;
        end else if (c < NC && f < FPC && n >= 1 && n <= NR) begin
          ph = 2; m_left = n; m_row = 0; m_col = c; m_frm = f;
        end else begin
          m_err = 1;
          if (n != 0) begin ph = 3; m_left = n; end
        end
      end
      2: begin
        m_rows[m_row] = w;
        m_row++;
        m_left--;
        if (m_left == 0) begin
          m_sidx = m_col * FPC + m_frm;
          ph = 1;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) ph = 1;
      end
    endcase
  endfunction

  always @(posedge CLK) begin
    if (resetn) begin
      logic [NR*32-1:0] efd;
      logic [SW-1:0]    est;
      m_sidx = -1;
      if (in_valid && m_rdy) model_word(in_data);
      m_rdy = (m_sidx < 0);
      #1;
      if (resetn) begin
        est = '0;
        if (m_sidx >= 0) est[m_sidx] = 1'b1;
        for (int r = 0; r < NR; r++) efd[r*32 +: 32] = m_rows[r];
        chk("cyc_ready", in_ready, m_rdy);
        chk("cyc_strobe", frame_strobe, est);
        chk("cyc_done", frame_done, m_sidx >= 0);
        chk("cyc_active", config_active, m_act);
        chk("cyc_err", cfg_err, m_err);
        chk("cyc_data", frame_data, efd);
      end
    end
  end

  task automatic send(input logic [31:0] w);
    int n;
    n = $urandom_range(0, gap_max);
    repeat (n) begin
      @(negedge CLK);
      in_valid = 1'b0;
      in_data  = $urandom;
    end
    @(negedge CLK);
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; !in_ready; i++) begin
      if (i > 100) begin
        n_checks++;
        $display("FAIL send_timeout got ready=0 want ready=1");
        break;
      end
      @(negedge CLK);
    end
    @(posedge CLK);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_reset(input bit at_neg);
    if (at_neg) @(negedge CLK);
    in_valid = 1'b0;
    resetn   = 1'b0;
    #1;
    chk("rst_data", frame_data, '0);
    chk("rst_strobe", frame_strobe, '0);
    chk("rst_ready", in_ready, 0);
    chk("rst_active", config_active, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", cfg_err, 0);
    model_reset();
    repeat (2) @(negedge CLK);
    resetn = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset(0);

    // basic frame with a pre-sync word that must be dropped
    send(32'h1234_5678);
    send(SYNC);
    send(32'h0203_0004);
    for (int i = 0; i < 4; i++) send(32'h1111_0000 + i);
    #1;
    chk("b_strobe43", frame_strobe[43], 1);
    chk("b_onehot", $countones(frame_strobe), 1);
    chk("b_done", frame_done, 1);
    chk("b_ready_gap", in_ready, 0);
    chk("b_active", config_active, 1);
    chk("b_row0", frame_data[31:0], 32'h1111_0000);
    chk("b_row3", frame_data[127:96], 32'h1111_0003);
    chk("b_upper", frame_data[NR*32-1:128], '0);

    // back-to-back frames
    send(32'h0000_0001);
    send(32'hDEAD_BEEF);
    #1;
    chk("bb_strobe0", frame_strobe[0], 1);
    send(32'h0F13_0010);
    for (int i = 0; i < 16; i++) send(32'h5500_0000 + i);
    #1;
    chk("bb_strobe319", frame_strobe[319], 1);
    chk("bb_row0", frame_data[31:0], 32'h5500_0000);
    chk("bb_row15", frame_data[511:480], 32'h5500_000F);

    // error paths
    send(32'h1000_0002);
    send(32'hAAAA_0001);
    send(32'hAAAA_0002);
    chk("e_err", cfg_err, 1);
    chk("e_row0_kept", frame_data[31:0], 32'h5500_0000);
    send(32'h0000_0000);
    chk("e_err_zero", cfg_err, 1);
    send(32'h0105_0002);
    send(DESYNC);
    send(32'hCAFE_0001);
    #1;
    chk("e_strobe25", frame_strobe[25], 1);
    chk("e_desync_data", frame_data[31:0], DESYNC);
    chk("e_still_active", config_active, 1);
    send(DESYNC);
    chk("e_desync", config_active, 0);
    send(SYNC);
    chk("e_sync_clr", cfg_err, 0);
    send(SYNC);
    chk("e_sync_in_hdr", cfg_err, 1);

    // async reset mid-data, then during strobe
    send(32'h0300_0004);
    send(32'h7777_0000);
    send(32'h7777_0001);
    do_reset(1);
    repeat (4) @(negedge CLK);
    send(SYNC);
    send(32'h0401_0004);
    for (int i = 0; i < 4; i++) send(32'h8888_0000 + i);
    #1;
    chk("r_strobe81", frame_strobe[81], 1);
    send(32'h0402_0004);
    for (int i = 0; i < 4; i++) send(32'h9999_0000 + i);
    #1;
    chk("r_strobe82", frame_strobe[82], 1);
    do_reset(0);
    repeat (4) @(negedge CLK);
    send(SYNC);
    send(32'h0500_0002);
    send(32'h4242_0000);
    send(32'h4242_0001);
    #1;
    chk("r_strobe100", frame_strobe[100], 1);
    chk("r_row1", frame_data[63:32], 32'h4242_0001);

    // randomized traffic with handshake gaps
    for (int f = 0; f < 40; f++) begin
      int k, n, c, fr;
      gap_max = $urandom_range(0, 3);
      k = $urandom_range(0, 9);
      if (k == 0) begin
        send(DESYNC);
        repeat ($urandom_range(0, 3)) send($urandom);
        send(SYNC);
      end else if (k == 1) begin
        if ($urandom_range(0, 1) == 1) begin
          c = $urandom_range(16, 255); fr = $urandom_range(0, 19);
        end else begin
          c = $urandom_range(0, 15); fr = $urandom_range(20, 255);
        end
        n = $urandom_range(0, 20);
        send({8'(c), 8'(fr), 8'($urandom), 8'(n)});
        repeat (n) send($urandom);
      end else begin
        c  = $urandom_range(0, NC - 1);
        fr = $urandom_range(0, FPC - 1);
        n  = $urandom_range(1, NR);
        send({8'(c), 8'(fr), 8'($urandom), 8'(n)});
        repeat (n) send($urandom);
      end
    end

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
